// File: rtl/spi_flash_master_if.sv
// Request/response bus between the boot sequencer and spi_flash_master.
interface spi_flash_master_if #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned LEN_W = $clog2(BYTES)
);
  logic                  s_valid;
  logic                  s_ready;
  logic                  s_last;
  logic [LEN_W-1:0]      s_len;
  logic [BYTES-1:0][7:0] s_wdata;
  logic [BYTES-1:0][7:0] m_rdata;
  logic                  m_rvalid;
  logic                  busy;

  modport master (
    output s_valid, s_last, s_len, s_wdata,
    input  s_ready, m_rdata, m_rvalid, busy
  );

  modport slave (
    input  s_valid, s_last, s_len, s_wdata,
    output s_ready, m_rdata, m_rvalid, busy
  );
endinterface

// File: rtl/spi_flash_master.sv
// SPI mode-0 NOR flash master: 1..BYTES full-duplex bytes per request, CS optionally held
// across requests so one flash command can span several requests.
module spi_flash_master #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned DIV   = 4,
  parameter int unsigned LEN_W = $clog2(BYTES)
) (
  input  logic              clk,
  input  logic              reset_n,
  spi_flash_master_if.slave bus,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_wp_n,
  output logic              spi_hold_n,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {StIdle, StLead, StShift, StStop, StEnd} state_e;

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW = $clog2(8 * BYTES + 1);
  localparam int unsigned NB = 8 * BYTES;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             last_q, last_d;
  logic [NB-1:0]    data_q, data_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             rvalid_q, rvalid_d;
  logic             accept;
  logic             tick;
  logic [BW-1:0]    bits_target;

  assign accept      = bus.s_valid && !busy_q;
  assign tick        = busy_q && (div_q == DW'(DIV - 1));
  assign bits_target = BW'(8 * (int'(len_q) + 1));

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    div_d    = div_q;
    bits_d   = bits_q;
    len_d    = len_q;
    last_d   = last_q;
    data_d   = data_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    rvalid_d = 1'b0;

    if (busy_q) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    if (accept) begin
      busy_d  = 1'b1;
      state_d = StIdle;
      len_d   = bus.s_len;
      last_d  = bus.s_last;
      data_d  = bus.s_wdata;
      div_d   = '0;
      bits_d  = '0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          // Re-driving CS low is harmless when the previous request held it.
          cs_n_d  = 1'b0;
          mosi_d  = data_q[NB-1];
          data_d  = data_q << 1;
          state_d = StLead;
        end
        StLead: begin
          sck_d   = 1'b1;
          state_d = StShift;
        end
        StShift: begin
          if (sck_q) begin
            sck_d            = 1'b0;
            {mosi_d, data_d} = {data_q, spi_miso};
            bits_d           = bits_q + BW'(1);
          end else if (bits_q == bits_target) begin
            // The tick that would have been the next rising edge ends the burst.
            mosi_d   = 1'b0;
            rvalid_d = 1'b1;
            state_d  = StStop;
          end else begin
            sck_d = 1'b1;
          end
        end
        StStop: begin
          cs_n_d  = last_q;
          state_d = StEnd;
        end
        StEnd: begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      div_q    <= '0;
      bits_q   <= '0;
      len_q    <= '0;
      last_q   <= 1'b0;
      data_q   <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      div_q    <= div_d;
      bits_q   <= bits_d;
      len_q    <= len_d;
      last_q   <= last_d;
      data_q   <= data_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.s_ready  = !busy_q;
  assign bus.busy     = busy_q;
  assign bus.m_rdata  = data_q;
  assign bus.m_rvalid = rvalid_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_wp_n     = 1'b1;
  assign spi_hold_n   = 1'b1;

  len_legal_a: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.s_valid && !busy_q) |-> (int'(bus.s_len) < int'(BYTES)));

endmodule

// File: tb/tb_spi_flash_master.sv
// Bench for spi_flash_master: timeline model of the pins checked every cycle on a DIV=2
// instance, plus literal expectations for the directed scenarios and a DIV=1 instance.
module tb_spi_flash_master;
  localparam int D = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_flash_master_if #(.BYTES(4), .LEN_W(2)) if1 ();
  spi_flash_master_if #(.BYTES(4), .LEN_W(2)) if2 ();

  logic cs1, sck1, mosi1, wp1, hold1, miso1;
  logic cs2, sck2, mosi2, wp2, hold2, miso2;

  spi_flash_master #(.BYTES(4), .DIV(D), .LEN_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1),
    .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_wp_n(wp1), .spi_hold_n(hold1),
    .spi_miso(miso1)
  );

  spi_flash_master #(.BYTES(4), .DIV(1), .LEN_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(if2),
    .spi_cs_n(cs2), .spi_sck(sck2), .spi_mosi(mosi2), .spi_wp_n(wp2), .spi_hold_n(hold2),
    .spi_miso(miso2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- flash slave models ----------------
  int          miso_mode = 0;  // 0: zeros, 1: loopback, 2: JEDEC-ID responder
  logic [23:0] jedec_id = 24'hEF4018;
  int          jr = 0;
  logic        jmiso = 1'b0;
  logic        jsck_prev = 1'b0;

  // Counts SCK rises within a CS-low window; bits after the 8-bit opcode come from the ID.
  always @(negedge clk) begin
    jsck_prev <= sck1;
    if (cs1) begin
      jr    <= 0;
      jmiso <= 1'b0;
    end else if (sck1 && !jsck_prev) begin
      jr    <= jr + 1;
      jmiso <= (jr + 1 >= 9 && jr + 1 <= 32) ? jedec_id[32-(jr+1)] : 1'b0;
    end
  end

  assign miso1 = (miso_mode == 1) ? mosi1 : (miso_mode == 2) ? jmiso : 1'b0;
  assign miso2 = mosi2;

  // ---------------- cycle counter and monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   cs_fall1 = 0, cs_rise1 = 0, cs_rise_n1 = 0, rdy_rise1 = 0, rv_cyc1 = 0, rv_n1 = 0;
  logic prev_cs1 = 1'b1, prev_rdy1 = 1'b1;
  int   rise1 = 0;
  logic [63:0] mosi_hist1 = '0;

  always @(negedge clk) begin
    if (prev_cs1 && !cs1) cs_fall1 <= cyc;
    if (!prev_cs1 && cs1) begin
      cs_rise1   <= cyc;
      cs_rise_n1 <= cs_rise_n1 + 1;
    end
    if (!prev_rdy1 && if1.s_ready) rdy_rise1 <= cyc;
    if (if1.m_rvalid) begin
      rv_cyc1 <= cyc;
      rv_n1   <= rv_n1 + 1;
    end
    prev_cs1  <= cs1;
    prev_rdy1 <= if1.s_ready;
  end

  always @(posedge sck1) begin
    rise1      <= rise1 + 1;
    mosi_hist1 <= {mosi_hist1[62:0], mosi1};
  end

  int   rdy_rise2 = 0, rv_cyc2 = 0, rise2 = 0;
  logic prev_rdy2 = 1'b1;
  always @(negedge clk) begin
    if (!prev_rdy2 && if2.s_ready) rdy_rise2 <= cyc;
    if (if2.m_rvalid) rv_cyc2 <= cyc;
    prev_rdy2 <= if2.s_ready;
  end
  always @(posedge sck2) rise2 <= rise2 + 1;

  // ---------------- behavioural model of dut1 ----------------
  logic [31:0] exp_rx = '0;
  logic        mdl_act = 1'b0;
  int          mdl_t = 0;
  int          mdl_n = 1;
  logic [31:0] mdl_wd = '0;
  logic [31:0] mdl_rx = '0;
  logic        mdl_last = 1'b1;
  logic        mdl_cs_idle = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_act     <= 1'b0;
      mdl_t       <= 0;
      mdl_cs_idle <= 1'b1;
    end else if (!mdl_act) begin
      if (if1.s_valid) begin
        mdl_act  <= 1'b1;
        mdl_t    <= 0;
        mdl_n    <= int'(if1.s_len) + 1;
        mdl_wd   <= if1.s_wdata;
        mdl_last <= if1.s_last;
        mdl_rx   <= (miso_mode == 1) ? (32'(if1.s_wdata) >> (8 * (3 - int'(if1.s_len))))
                                     : exp_rx;
      end
    end else if (mdl_t + 1 == D * (4 + 16 * mdl_n)) begin
      mdl_act     <= 1'b0;
      mdl_cs_idle <= mdl_last;
    end else begin
      mdl_t <= mdl_t + 1;
    end
  end

  int          ct, cn;
  logic        e_cs, e_sck, e_mosi, e_rv, mosi_on;
  logic [63:0] mask;

  always @(negedge clk) begin
    if (reset_n) begin
      e_cs    = mdl_cs_idle;
      e_sck   = 1'b0;
      e_mosi  = 1'b0;
      e_rv    = 1'b0;
      mosi_on = 1'b1;
      ct      = mdl_t;
      cn      = mdl_n;
      mask    = (64'd1 << (8 * cn)) - 64'd1;
      if (mdl_act) begin
        if (ct >= D) e_cs = (ct < D * (3 + 16 * cn)) ? 1'b0 : mdl_last;
        if (ct >= 2 * D && ct < D * (2 + 16 * cn)) e_sck = (((ct - 2 * D) / D) % 2 == 0);
        if (ct >= D && ct < D * (1 + 16 * cn)) e_mosi = mdl_wd[31-(ct-D)/(2*D)];
        else if (ct >= D * (1 + 16 * cn) && ct < D * (2 + 16 * cn)) mosi_on = 1'b0;
        e_rv = (ct == D * (2 + 16 * cn));
      end
      chk("busy", 64'(if1.busy), 64'(mdl_act));
      chk("s_ready", 64'(if1.s_ready), 64'(!mdl_act));
      chk("cs_n", 64'(cs1), 64'(e_cs));
      chk("sck", 64'(sck1), 64'(e_sck));
      if (mosi_on) chk("mosi", 64'(mosi1), 64'(e_mosi));
      chk("m_rvalid", 64'(if1.m_rvalid), 64'(e_rv));
      if (e_rv) chk("m_rdata", 64'(if1.m_rdata) & mask, 64'(mdl_rx) & mask);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send1(input int len, input logic last, input logic [31:0] wd, output int acc);
    if1.s_len   = 2'(len);
    if1.s_last  = last;
    if1.s_wdata = wd;
    if1.s_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    if1.s_valid = 1'b0;
  endtask

  task automatic wait_idle1(input string name);
    int k = 0;
    while (!if1.s_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!if1.s_ready) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: s_ready=%0b, expected 1", name, if1.s_ready);
    end
    @(negedge clk);
  endtask

  initial begin
    int acc, base, rvb, csb, k;
    if1.s_valid = 1'b0; if1.s_len = '0; if1.s_last = 1'b0; if1.s_wdata = '0;
    if2.s_valid = 1'b0; if2.s_len = '0; if2.s_last = 1'b0; if2.s_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_cs_n", 64'(cs1), 64'd1);
    chk("rst_sck", 64'(sck1), 64'd0);
    chk("rst_mosi", 64'(mosi1), 64'd0);
    chk("rst_busy", 64'(if1.busy), 64'd0);
    chk("rst_s_ready", 64'(if1.s_ready), 64'd1);
    chk("rst_m_rvalid", 64'(if1.m_rvalid), 64'd0);
    chk("rst_m_rdata", 64'(if1.m_rdata), 64'd0);
    chk("wp_hold", {62'd0, wp1, hold1}, 64'd3);
    reset_n = 1'b1;
    @(negedge clk);

    // Single-byte 0x9F, DIV=2.
    miso_mode = 0; exp_rx = '0; base = rise1;
    send1(0, 1'b1, 32'h9F00_0000, acc);
    wait_idle1("t1");
    chk("t1_mosi_bits", 64'(mosi_hist1[7:0]), 64'h9F);
    chk("t1_rises", 64'(rise1 - base), 64'd8);
    chk("t1_rvalid_clk", 64'(rv_cyc1 - acc), 64'd36);
    chk("t1_cs_fall_clk", 64'(cs_fall1 - acc), 64'd2);
    chk("t1_cs_rise_clk", 64'(cs_rise1 - acc), 64'd38);
    chk("t1_ready_clk", 64'(rdy_rise1 - acc), 64'd40);

    // JEDEC ID read across two requests with CS held.
    miso_mode = 2; exp_rx = '0; csb = cs_rise_n1;
    send1(0, 1'b0, 32'h9F00_0000, acc);
    wait_idle1("t2a");
    chk("t2_cs_held", 64'(cs1), 64'd0);
    chk("t2_no_cs_rise", 64'(cs_rise_n1 - csb), 64'd0);
    exp_rx = 32'h00EF_4018; base = rise1;
    send1(2, 1'b1, 32'h0000_0000, acc);
    wait_idle1("t2b");
    chk("t2_id", 64'(if1.m_rdata[2:0]), 64'hEF4018);
    chk("t2_rises", 64'(rise1 - base), 64'd24);
    chk("t2_cs_released", 64'(cs1), 64'd1);

    // Full width loopback.
    miso_mode = 1; base = rise1;
    send1(3, 1'b1, 32'h0312_3456, acc);
    wait_idle1("t3");
    chk("t3_rdata", 64'(if1.m_rdata), 64'h0312_3456);
    chk("t3_rises", 64'(rise1 - base), 64'd32);

    // Backpressure: s_valid held with changing data; second request lands at s_ready rise.
    base = rise1; rvb = rv_n1;
    if1.s_len = 2'd0; if1.s_last = 1'b1; if1.s_wdata = 32'hA511_2233; if1.s_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    for (int i = 0; i < 40; i++) begin
      if1.s_wdata = $urandom;
      @(negedge clk);
    end
    if1.s_wdata = 32'h3C77_8899;
    @(negedge clk);
    if1.s_valid = 1'b0;
    wait_idle1("t4");
    chk("t4_mosi_bits", 64'(mosi_hist1[15:0]), 64'hA53C);
    chk("t4_rvalids", 64'(rv_n1 - rvb), 64'd2);
    // Ready rises at +40, handshake completes at the next edge, CS falls DIV later.
    chk("t4_second_cs_fall", 64'(cs_fall1 - acc), 64'd43);

    // Reset at the 5th rising SCK edge.
    base = rise1; rvb = rv_n1;
    send1(3, 1'b1, 32'hDEAD_BEEF, acc);
    k = 0;
    while (rise1 - base < 5 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("t5_reached_rise5", 64'(rise1 - base >= 5), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_cs_n", 64'(cs1), 64'd1);
    chk("t5_sck", 64'(sck1), 64'd0);
    chk("t5_mosi", 64'(mosi1), 64'd0);
    chk("t5_busy", 64'(if1.busy), 64'd0);
    chk("t5_rvalid", 64'(if1.m_rvalid), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_no_rvalid", 64'(rv_n1 - rvb), 64'd0);
    send1(1, 1'b1, 32'h5AC3_0000, acc);
    wait_idle1("t5b");
    chk("t5_after_rdata", 64'(if1.m_rdata[1:0]), 64'h5AC3);
    chk("t5_after_rvalids", 64'(rv_n1 - rvb), 64'd1);

    // DIV=1 instance, two bytes.
    base = rise2;
    if2.s_len = 2'd1; if2.s_last = 1'b1; if2.s_wdata = 32'hC35A_0000; if2.s_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    if2.s_valid = 1'b0;
    k = 0;
    while (!if2.s_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t6_done", 64'(if2.s_ready), 64'd1);
    @(negedge clk);
    chk("t6_rvalid_clk", 64'(rv_cyc2 - acc), 64'd34);
    chk("t6_ready_clk", 64'(rdy_rise2 - acc), 64'd36);
    chk("t6_rises", 64'(rise2 - base), 64'd16);
    chk("t6_rdata", 64'(if2.m_rdata[1:0]), 64'hC35A);
    chk("t6_cs_idle", 64'(cs2), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
